// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the shared memory bus for CPU_QUANTITY cores.
// Sequence per transaction: IDLE (arbitrate) -> ACCESS (strobe held until matching dn)
// -> RELEASE (req_dn pulse, strobes low) -> IDLE.
// Optional build macro ARB_TIMEOUT_EN: ends a stalled ACCESS after TIMEOUT cycles with an err pulse.
module mem_bus_arbiter #(
  parameter int unsigned CPU_QUANTITY = 3,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CPU_QUANTITY-1:0]        req_rd,
  input  logic [CPU_QUANTITY-1:0]        req_wr,
  input  logic [CPU_QUANTITY*ADDR_W-1:0] req_addr,
  input  logic [CPU_QUANTITY*DATA_W-1:0] req_wdata,
  output logic [CPU_QUANTITY-1:0]        grant,
  output logic [CPU_QUANTITY-1:0]        req_dn,
  output logic [DATA_W-1:0]              req_rdata,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           mem_read_q,
  output logic                           mem_write_q,
  input  logic                           mem_read_dn,
  input  logic                           mem_write_dn,
  output logic                           bus_busy,
  output logic                           err
);

  localparam int unsigned IDX_W = (CPU_QUANTITY > 1) ? $clog2(CPU_QUANTITY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RELEASE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] owner;

  logic [CPU_QUANTITY-1:0] pending;
  logic                    found;
  logic [IDX_W-1:0]        pick;
  int unsigned             cand;
  logic                    sel_rd;
  logic                    sel_wr;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;
  logic                    mem_done;
  logic                    tmo_hit;

  // Round-robin pick: first pending requester after last_owner, wrapping, plus its request fields.
  always_comb begin
    pending   = req_rd | req_wr;
    found     = 1'b0;
    pick      = '0;
    cand      = 0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned off = 1; off <= CPU_QUANTITY; off++) begin
      cand = 32'(last_owner) + off;
      if (cand >= CPU_QUANTITY) cand = cand - CPU_QUANTITY;
      if (!found && pending[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
    for (int unsigned i = 0; i < CPU_QUANTITY; i++) begin
      if (pick == IDX_W'(i)) begin
        sel_rd    = req_rd[i];
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only the completion matching the issued operation ends ACCESS; stray dn is ignored.
  always_comb begin
    mem_done = (mem_read_q && mem_read_dn) || (mem_write_q && mem_write_dn);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] tmo_cnt;

  // Watchdog reaches its limit on the TIMEOUT-th ACCESS edge without a matching dn.
  always_comb begin
    tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Watchdog counter, cleared on ACCESS entry.
  always_ff @(posedge clk) begin
    if (rst || state != S_ACCESS) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  // No watchdog: ACCESS waits for the memory indefinitely.
  always_comb begin
    tmo_hit = 1'b0;
  end

  // TIMEOUT only matters with the watchdog built in.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // Arbitration FSM with registered grant, bus and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_owner  <= IDX_W'(CPU_QUANTITY - 1);
      owner       <= '0;
      grant       <= '0;
      req_dn      <= '0;
      req_rdata   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      bus_busy    <= 1'b0;
      err         <= 1'b0;
    end else begin
      req_dn <= '0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            owner       <= pick;
            grant       <= CPU_QUANTITY'(1) << pick;
            mem_addr    <= sel_addr;
            mem_wdata   <= sel_wdata;
            // Write takes precedence when both requests are raised.
            mem_write_q <= sel_wr;
            mem_read_q  <= sel_rd & ~sel_wr;
            bus_busy    <= 1'b1;
            state       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_done || tmo_hit) begin
            if (mem_done && mem_read_q) req_rdata <= mem_rdata;
            err         <= ~mem_done;
            req_dn      <= grant;
            last_owner  <= owner;
            grant       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state       <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          bus_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors plus hand-written multi-cycle sequences for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_rd;
  logic [2:0]  req_wr;
  logic [95:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  grant;
  logic [2:0]  req_dn;
  logic [31:0] req_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        mem_read_dn;
  logic        mem_write_dn;
  logic        bus_busy;
  logic        err;

  // Memory responder: answers mem_lat cycles after the strobe rises, while mem_auto is set.
  int unsigned mem_lat  = 0;
  bit          mem_auto = 1'b1;
  bit          force_rd_dn = 1'b0;
  int unsigned acc_cnt  = 0;
  logic [31:0] rdata_val = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read_q || mem_write_q) acc_cnt <= acc_cnt + 1;
    else                           acc_cnt <= 0;
  end

  assign mem_rdata    = rdata_val;
  assign mem_read_dn  = force_rd_dn | (mem_auto & mem_read_q & (acc_cnt >= mem_lat));
  assign mem_write_dn = mem_auto & mem_write_q & (acc_cnt >= mem_lat);

  mem_bus_arbiter #(
    .CPU_QUANTITY(3),
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_rd(req_rd),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .grant(grant),
    .req_dn(req_dn),
    .req_rdata(req_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_read_q(mem_read_q),
    .mem_write_q(mem_write_q),
    .mem_read_dn(mem_read_dn),
    .mem_write_dn(mem_write_dn),
    .bus_busy(bus_busy),
    .err(err)
  );

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  wr;
    int unsigned lat;
    logic [31:0] rdata;
    logic [2:0]  exp_grant;
    logic        exp_rq;
    logic        exp_wq;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One full transaction from a table record: grant/bus values, completion latency, result.
  task automatic run_vec(input vec_t v, input int k);
    int  n;
    bit  got;
    req_rd    = v.rd;
    req_wr    = v.wr;
    mem_lat   = v.lat;
    rdata_val = v.rdata;
    tick();
    chk($sformatf("v%0d_grant", k), 64'(grant), 64'(v.exp_grant));
    chk($sformatf("v%0d_rq", k), 64'(mem_read_q), 64'(v.exp_rq));
    chk($sformatf("v%0d_wq", k), 64'(mem_write_q), 64'(v.exp_wq));
    chk($sformatf("v%0d_addr", k), 64'(mem_addr), 64'(v.exp_addr));
    chk($sformatf("v%0d_wdata", k), 64'(mem_wdata), 64'(v.exp_wdata));
    chk($sformatf("v%0d_busy", k), 64'(bus_busy), 64'd1);
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      tick();
      n++;
      if (req_dn != 3'b000) got = 1'b1;
    end
    chk($sformatf("v%0d_dn_seen", k), 64'(got), 64'd1);
    chk($sformatf("v%0d_dn", k), 64'(req_dn), 64'(v.exp_grant));
    chk($sformatf("v%0d_edges", k), 64'(n), 64'(v.lat + 1));
    chk($sformatf("v%0d_rdata", k), 64'(req_rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d_rel_grant", k), 64'(grant), 64'd0);
    chk($sformatf("v%0d_rel_strobes", k), 64'({mem_read_q, mem_write_q}), 64'd0);
    chk($sformatf("v%0d_err", k), 64'(err), 64'd0);
    req_rd = '0;
    req_wr = '0;
    tick();
    chk($sformatf("v%0d_dn_once", k), 64'(req_dn), 64'd0);
    chk($sformatf("v%0d_idle_busy", k), 64'(bus_busy), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_dn"}, 64'(req_dn), 64'd0);
    chk({tag, "_rdata"}, 64'(req_rdata), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_strobes"}, 64'({mem_read_q, mem_write_q}), 64'd0);
    chk({tag, "_busy"}, 64'(bus_busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] rr_grant[9];
    logic [2:0] rr_dn[9];
    int  n;
    bit  got;

    // CPU0 @0x00, CPU1 @0x10, CPU2 @0x20
    req_addr  = {32'h0000_0020, 32'h0000_0010, 32'h0000_0000};
    req_wdata = {32'h1234_5678, 32'h1111_2222, 32'hA0A0_0000};
    req_rd = '0;
    req_wr = '0;

    //             rd      wr      lat rdata          grant   rq wq addr   wdata          exp_rdata
    vecs[0] = '{3'b010, 3'b000, 2, 32'hDEADBEEF, 3'b010, 1, 0, 32'h10, 32'h1111_2222, 32'hDEADBEEF};
    vecs[1] = '{3'b000, 3'b100, 1, 32'h0,        3'b100, 0, 1, 32'h20, 32'h1234_5678, 32'hDEADBEEF};
    vecs[2] = '{3'b001, 3'b001, 0, 32'h0,        3'b001, 0, 1, 32'h00, 32'hA0A0_0000, 32'hDEADBEEF};
    vecs[3] = '{3'b111, 3'b000, 0, 32'h1,        3'b010, 1, 0, 32'h10, 32'h1111_2222, 32'h1};
    vecs[4] = '{3'b101, 3'b000, 0, 32'h2,        3'b100, 1, 0, 32'h20, 32'h1234_5678, 32'h2};
    vecs[5] = '{3'b101, 3'b000, 0, 32'h3,        3'b001, 1, 0, 32'h00, 32'hA0A0_0000, 32'h3};
    vecs[6] = '{3'b011, 3'b000, 1, 32'h4,        3'b010, 1, 0, 32'h10, 32'h1111_2222, 32'h4};
    vecs[7] = '{3'b000, 3'b001, 0, 32'h5,        3'b001, 0, 1, 32'h00, 32'hA0A0_0000, 32'h4};

    // Grant/req_dn each cycle with all three holding req_rd and a same-cycle memory answer.
    rr_grant = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001};
    rr_dn    = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};

    rst = 1'b1;
    tick();
    tick();
    chk_zero("rst0");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Write to CPU2 with a stray read_dn in its first ACCESS cycle.
    req_wr  = 3'b100;
    mem_lat = 2;
    tick();
    chk("t4_wq", 64'({mem_read_q, mem_write_q}), 64'b01);
    chk("t4_addr", 64'(mem_addr), 64'h20);
    chk("t4_wdata", 64'(mem_wdata), 64'h1234_5678);
    force_rd_dn = 1'b1;
    tick();
    force_rd_dn = 1'b0;
    chk("t4_stray_wq", 64'(mem_write_q), 64'd1);
    chk("t4_stray_dn", 64'(req_dn), 64'd0);
    chk("t4_stray_grant", 64'(grant), 64'b100);
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      tick();
      n++;
      if (req_dn != 3'b000) got = 1'b1;
    end
    chk("t4_dn", 64'(req_dn), 64'b100);
    chk("t4_rdata", 64'(req_rdata), 64'h4);
    req_wr = '0;
    tick();

    // CPU0 raises both; only the write strobe is driven; request dropped mid-ACCESS.
    req_rd  = 3'b001;
    req_wr  = 3'b001;
    mem_lat = 2;
    tick();
    chk("t5_strobes", 64'({mem_read_q, mem_write_q}), 64'b01);
    req_rd = '0;
    req_wr = '0;
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      tick();
      n++;
      if (req_dn != 3'b000) got = 1'b1;
    end
    chk("t5_dn", 64'(req_dn), 64'b001);
    tick();

    // Reset held two cycles in the middle of an ACCESS.
    req_rd  = 3'b100;
    mem_lat = 100;
    tick();
    chk("t1_grant", 64'(grant), 64'b100);
    rst = 1'b1;
    tick();
    tick();
    chk_zero("t1");
    rst     = 1'b0;
    req_rd  = 3'b111;
    mem_lat = 0;
    tick();
    chk("t1_first_grant", 64'(grant), 64'b001);

    for (int c = 0; c < 9; c++) begin
      tick();
      chk($sformatf("t3_grant_c%0d", c), 64'(grant), 64'(rr_grant[c]));
      chk($sformatf("t3_dn_c%0d", c), 64'(req_dn), 64'(rr_dn[c]));
    end
    req_rd = '0;
    tick();
    tick();
    tick();
    chk("t3_rdata", 64'(req_rdata), 64'h5);
    chk("t3_idle_busy", 64'(bus_busy), 64'd0);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: err and req_dn after the 4th ACCESS edge.
    mem_auto  = 1'b0;
    rdata_val = 32'h0000_0BAD;
    req_rd    = 3'b110;
    tick();
    chk("t6_grant", 64'(grant), 64'b010);
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      tick();
      n++;
      if (err) got = 1'b1;
    end
    chk("t6_err_edges", 64'(n), 64'd4);
    chk("t6_dn", 64'(req_dn), 64'b010);
    chk("t6_rdata", 64'(req_rdata), 64'h5);
    tick();
    chk("t6_err_once", 64'(err), 64'd0);
    mem_auto = 1'b1;
    req_rd   = 3'b100;
    n = 0;
    got = 1'b0;
    while (n < 10 && !got) begin
      tick();
      n++;
      if (grant != 3'b000) got = 1'b1;
    end
    chk("t6_next_grant", 64'(grant), 64'b100);
`else
    // Memory never answers: ACCESS holds with no err.
    mem_auto = 1'b0;
    req_rd   = 3'b010;
    tick();
    for (int c = 0; c < 10; c++) tick();
    chk("stall_err", 64'(err), 64'd0);
    chk("stall_rq", 64'(mem_read_q), 64'd1);
    chk("stall_dn", 64'(req_dn), 64'd0);
    mem_auto = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 10 && !got) begin
      tick();
      n++;
      if (req_dn != 3'b000) got = 1'b1;
    end
    chk("stall_release_dn", 64'(req_dn), 64'b010);
`endif
    req_rd = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
